// File: rtl/mem_pkg.sv
// mem_pkg: memory op codes, unit state encoding and RAM sizing shared by the load/store engine
package mem_pkg;
  localparam int unsigned DEPTH_WORDS_DEF = 16384;
  localparam logic [7:0] MEM_ERROR   = 8'd0;
  localparam logic [7:0] LOAD_BYTE   = 8'd1;
  localparam logic [7:0] LOAD_HALF   = 8'd2;
  localparam logic [7:0] LOAD_WORD   = 8'd3;
  localparam logic [7:0] LOAD_BYTE_U = 8'd4;
  localparam logic [7:0] LOAD_HALF_U = 8'd5;
  localparam logic [7:0] STORE_BYTE  = 8'd6;
  localparam logic [7:0] STORE_HALF  = 8'd7;
  localparam logic [7:0] STORE_WORD  = 8'd8;
  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_e;
  function automatic logic access_err(input logic [7:0] op, input logic [31:0] addr, input int unsigned depth);
    return op == MEM_ERROR || op > STORE_WORD
      || ((op == LOAD_HALF || op == LOAD_HALF_U || op == STORE_HALF) && addr[0])
      || ((op == LOAD_WORD || op == STORE_WORD) && addr[1:0] != 2'b00)
      || {32'b0, addr} >= {30'b0, depth, 2'b00};
  endfunction
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: core-side request/response port of the load/store engine
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  modport master (output req_valid, req_op, req_addr, req_wdata, input req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave (input req_valid, req_op, req_addr, req_wdata, output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: little-endian lane select with sign/zero extension for loads and byte/half merge for stores
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [7:0]  op_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_word_o
);
  logic [4:0]  sh;
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] bmask;
  logic [31:0] hmask;
  assign sh    = {addr_i, 3'b000};
  assign b     = 8'(word_i >> sh);
  assign h     = addr_i[1] ? word_i[31:16] : word_i[15:0];
  assign bmask = 32'h0000_00FF << sh;
  assign hmask = addr_i[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
  assign ld_data_o = op_i == LOAD_BYTE   ? {{24{b[7]}}, b}
                   : op_i == LOAD_BYTE_U ? {24'b0, b}
                   : op_i == LOAD_HALF   ? {{16{h[15]}}, h}
                   : op_i == LOAD_HALF_U ? {16'b0, h}
                   : word_i;
  assign st_word_o = op_i == STORE_BYTE ? (word_i & ~bmask) | ({24'b0, wdata_i[7:0]} << sh)
                   : op_i == STORE_HALF ? (word_i & ~hmask) | ({2{wdata_i[15:0]}} & hmask)
                   : wdata_i;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store engine between the core memory port and a synchronous-read RAM
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS),
  parameter int unsigned RAM_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_unit_if.slave  bus,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_wren_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i
);
  localparam int unsigned CNT_W = $clog2(RAM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAM_LAT - 1);
  state_e            state_q;
  logic [7:0]        op_q;
  logic [1:0]        lane_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       rsp_rdata_q;
  logic [31:0]       rsp_rdata_d;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [31:0]       ld_data;
  logic [31:0]       st_word;
  logic              is_load;
  logic              acc_err;
  mem_lane_align u_align (
    .word_i    (ram_rdata_i),
    .addr_i    (lane_q),
    .op_i      (op_q),
    .wdata_i   (wdata_q),
    .ld_data_o (ld_data),
    .st_word_o (st_word)
  );
  assign acc_err = access_err(bus.req_op, bus.req_addr, DEPTH_WORDS);
  assign is_load = op_q >= LOAD_BYTE && op_q <= LOAD_HALF_U;
  // read data lands in the RESP/WR cycle itself, so it is used straight from the RAM port there
  assign rsp_rdata_d   = state_q == RESP ? (is_load && !err_q ? ld_data : '0) : rsp_rdata_q;
  assign bus.req_ready = state_q == IDLE;
  assign bus.rsp_valid = state_q == RESP;
  assign bus.rsp_err   = state_q == RESP && err_q;
  assign bus.rsp_rdata = rsp_rdata_d;
  assign ram_addr_o    = ram_addr_q;
  assign ram_wren_o    = state_q == WR;
  assign ram_wdata_o   = state_q == WR ? st_word : '0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      op_q        <= MEM_ERROR;
      lane_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      rsp_rdata_q <= '0;
      ram_addr_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.req_valid) begin
          op_q       <= bus.req_op;
          lane_q     <= bus.req_addr[1:0];
          wdata_q    <= bus.req_wdata;
          ram_addr_q <= bus.req_addr[ADDR_W+1:2];
          err_q      <= acc_err;
          cnt_q      <= '0;
          state_q    <= acc_err ? RESP
                      : bus.req_op == STORE_WORD ? WR
                      : bus.req_op == STORE_BYTE || bus.req_op == STORE_HALF ? RMW_RD
                      : RD;
        end
        RD, RMW_RD: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_q <= state_q == RD ? RESP : WR;
        end
        WR: state_q <= RESP;
        RESP: begin
          rsp_rdata_q <= rsp_rdata_d;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized checks of the load/store engine against a word-array reference model
module tb_mem_access_unit;
  localparam int unsigned DEPTH   = 16384;
  localparam int unsigned RAM_LAT = 1;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] ram_addr;
  logic        ram_wren;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic        pre_we = 1'b0;
  logic [13:0] pre_a = '0;
  logic [31:0] pre_d = '0;
  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] ref_mem [0:DEPTH-1];
  int n_vec = 0;
  int n_err = 0;

  mem_access_unit_if bus ();

  mem_access_unit #(.DEPTH_WORDS(DEPTH), .ADDR_W(14), .RAM_LAT(RAM_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .ram_addr_o  (ram_addr),
    .ram_wren_o  (ram_wren),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) mem[pre_a] <= pre_d;
    else if (ram_wren) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       output logic err, output logic [31:0] rd, output int lat,
                       output int nwr, output logic [31:0] ww);
    logic [31:0] w, b, h;
    int bs, hs;
    err = op == 0 || op > 8 || ((op == 2 || op == 5 || op == 7) && addr % 2 != 0)
       || ((op == 3 || op == 8) && addr % 4 != 0) || addr >= DEPTH * 4;
    w = '0;
    if (!err) w = ref_mem[addr / 4];
    bs = 8 * int'(addr % 4);
    hs = 16 * int'((addr / 2) % 2);
    b = (w >> bs) % 256;
    h = (w >> hs) % 65536;
    rd = '0;
    ww = '0;
    if (!err) begin
      case (op)
        8'd1: rd = b >= 128 ? b - 256 : b;
        8'd2: rd = h >= 32768 ? h - 65536 : h;
        8'd3: rd = w;
        8'd4: rd = b;
        8'd5: rd = h;
        8'd6: ww = w - (b << bs) + ((wd % 256) << bs);
        8'd7: ww = w - (h << hs) + ((wd % 65536) << hs);
        8'd8: ww = wd;
        default: ;
      endcase
    end
    lat = err ? 1 : (op == 6 || op == 7) ? RAM_LAT + 2 : op == 8 ? 2 : RAM_LAT + 1;
    nwr = (!err && op >= 6) ? 1 : 0;
  endtask

  task automatic do_req(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wd, output logic [31:0] got);
    logic        e_err;
    logic [31:0] e_rd, e_ww, ww;
    int e_lat, e_nwr, cyc, nwr, g;
    model(op, addr, wd, e_err, e_rd, e_lat, e_nwr, e_ww);
    g = 0;
    @(negedge clk);
    while (!bus.req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("ready", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    @(posedge clk);
    cyc = 0;
    nwr = 0;
    ww  = '0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        bus.req_valid = 1'b0;
        bus.req_op    = 8'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        if (!e_err) chk("ram_addr", ram_addr, addr[15:2]);
      end
      if (ram_wren) begin
        nwr++;
        ww = ram_wdata;
      end
    end while (!bus.rsp_valid && cyc < 12);
    chk($sformatf("latency op%0d", op), cyc, e_lat);
    chk($sformatf("rsp_err op%0d", op), bus.rsp_err, e_err);
    chk($sformatf("rsp_rdata op%0d @%h", op, addr), bus.rsp_rdata, e_rd);
    chk("wren_count", nwr, e_nwr);
    if (e_nwr == 1) chk("ram_wdata", ww, e_ww);
    got = bus.rsp_rdata;
    @(negedge clk);
    chk("rsp_one_cycle", bus.rsp_valid, 0);
    chk("rdata_hold", bus.rsp_rdata, e_rd);
    if (e_nwr == 1) ref_mem[addr / 4] = e_ww;
  endtask

  initial begin
    logic [31:0] got, t, wd, bb_wd, a;
    logic [7:0]  op;
    int r, rsp_n;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < 16; i++) ref_mem[32'h400 + i] = '0;
    #2 rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pre_we = 1'b1;
      pre_a  = 14'(32'h400 + i);
      pre_d  = i == 0 ? 32'h80FF7F01 : $urandom;
      ref_mem[32'h400 + i] = pre_d;
    end
    @(negedge clk);
    pre_we = 1'b0;
    chk("reset req_ready", bus.req_ready, 1);
    chk("reset rsp_valid", bus.rsp_valid, 0);
    chk("reset rsp_rdata", bus.rsp_rdata, 0);
    chk("reset rsp_err", bus.rsp_err, 0);
    chk("reset ram_wren", ram_wren, 0);
    chk("reset ram_addr", ram_addr, 0);
    chk("reset ram_wdata", ram_wdata, 0);
    @(negedge clk);
    rst = 1'b1;

    do_req(8'd1, 32'h1003, 32'h0, got);
    chk("lb_sign", got, 32'hFFFFFF80);
    do_req(8'd5, 32'h1002, 32'h0, got);
    chk("lhu_zero", got, 32'h000080FF);
    do_req(8'd2, 32'h1002, 32'h0, got);
    chk("lh_sign", got, 32'hFFFF80FF);
    do_req(8'd3, 32'h1000, 32'h0, got);
    chk("lw_word", got, 32'h80FF7F01);
    do_req(8'd6, 32'h1001, 32'h000000AB, got);
    do_req(8'd3, 32'h1000, 32'h0, got);
    chk("sb_merge", got, 32'h80FFAB01);
    do_req(8'd3, 32'h1002, 32'h0, got);
    do_req(8'd7, 32'h1001, 32'h1234, got);
    do_req(8'd9, 32'h1000, 32'h0, got);
    do_req(8'd3, DEPTH * 4, 32'h0, got);

    bb_wd = $urandom;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 8'd8;
    bus.req_addr  = 32'h1008;
    bus.req_wdata = bb_wd;
    @(posedge clk);
    rsp_n = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) bus.req_op = 8'd3;
      if (c == 4) bus.req_valid = 1'b0;
      chk($sformatf("b2b ready c%0d", c), bus.req_ready, (c == 3 || c >= 6) ? 1 : 0);
      chk($sformatf("b2b wren c%0d", c), ram_wren, c == 1 ? 1 : 0);
      chk($sformatf("b2b rsp c%0d", c), bus.rsp_valid, (c == 2 || c == 5) ? 1 : 0);
      if (bus.rsp_valid) begin
        rsp_n++;
        if (rsp_n == 2) chk("b2b lw data", bus.rsp_rdata, bb_wd);
      end
    end
    chk("b2b rsp count", rsp_n, 2);
    ref_mem[32'h402] = bb_wd;

    t  = ref_mem[32'h403];
    wd = {24'b0, ~t[15:8]};
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 8'd6;
    bus.req_addr  = 32'h100D;
    bus.req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("abort rmw_rd wren", ram_wren, 0);
    @(negedge clk);
    chk("abort wr wren", ram_wren, 1);
    #1 rst = 1'b0;
    #1;
    chk("abort wren async", ram_wren, 0);
    chk("abort req_ready", bus.req_ready, 1);
    chk("abort rsp_valid", bus.rsp_valid, 0);
    chk("abort rsp_rdata", bus.rsp_rdata, 0);
    chk("abort rsp_err", bus.rsp_err, 0);
    chk("abort ram_addr", ram_addr, 0);
    chk("abort ram_wdata", ram_wdata, 0);
    @(posedge clk);
    @(negedge clk);
    chk("abort held wren", ram_wren, 0);
    rst = 1'b1;
    do_req(8'd3, 32'h100C, 32'h0, got);
    chk("abort word unchanged", got, t);

    for (int i = 0; i < 150; i++) begin
      r  = int'($urandom_range(0, 15));
      op = r == 0 ? 8'($urandom_range(9, 255)) : r == 1 ? 8'd0 : 8'($urandom_range(1, 8));
      a  = $urandom_range(0, 15) == 0 ? DEPTH * 4 + $urandom_range(0, 1024) : 32'h1000 + $urandom_range(0, 63);
      do_req(op, a, $urandom, got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store engine between the CPU core's memory port and a word-wide synchronous-read RAM.
- Accepts one request at a time, using the team's 8-bit memory op codes (LOAD_BYTE..STORE_WORD).
- Performs lane selection and sign/zero extension for loads, and read-modify-write for byte/half stores.
- Flags misaligned, out-of-range and illegal-op accesses, and returns a one-cycle response pulse to the core FSM.

Parameters:
- DEPTH_WORDS, 16384: RAM depth in 32-bit words; valid byte addresses are 0..DEPTH_WORDS*4-1.
- ADDR_W, 14: RAM word-address width; must equal clog2(DEPTH_WORDS).
- RAM_LAT, 1: RAM read latency in cycles from ram_addr valid to ram_rdata valid; must be >=1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- req_valid  in  1  request strobe from core
- req_ready  out  1  unit idle, can accept
- req_op  in  8  0=MEM_ERROR, 1=LB, 2=LH, 3=LW, 4=LBU, 5=LHU, 6=SB, 7=SH, 8=SW
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low byte/half used for SB/SH
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; held until the next response
- rsp_err  out  1  access error, qualified by rsp_valid
- ram_addr  out  ADDR_W  word address (latched req_addr[ADDR_W+1:2])
- ram_wren  out  1  RAM write enable
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, ram_wren=0, ram_addr=0, ram_wdata=0; state IDLE.
- Reset mid-operation aborts immediately. ram_wren drops asynchronously because it is decoded from state. No partial write completes.
- States: IDLE, RD, RMW_RD, WR, RESP.
- Handshake:
  - Accept on the edge where req_valid & req_ready. req_ready=1 only in IDLE.
  - op, addr and wdata are latched at accept. Request inputs are ignored outside IDLE.
- Cycle timing: cycle 1 is the cycle following the accept edge.
- Error check at accept (combinational on req_*):
  - op 0 or >8 is an error.
  - LH/LHU/SH with addr[0]=1 is an error.
  - LW/SW with addr[1:0]!=0 is an error.
  - addr >= DEPTH_WORDS*4 is an error.
  - Error path goes IDLE->RESP: rsp_valid=1, rsp_err=1 in cycle 1, rsp_rdata=0, no RAM access.
- Load (1-5):
  - IDLE->RD for RAM_LAT cycles, then RESP. rsp_valid is high in cycle RAM_LAT+1.
  - Byte lane = addr[1:0], little-endian. Half lane = addr[1].
  - LB/LH sign-extend. LBU/LHU zero-extend. LW passes the word through.
- SW: IDLE->WR (ram_wren=1, ram_wdata=wdata, cycle 1) ->RESP (cycle 2). rsp_rdata=0.
- SB/SH:
  - IDLE->RMW_RD for RAM_LAT cycles, then WR, then RESP in cycle RAM_LAT+2.
  - ram_wdata = captured word with only the addressed byte/half replaced.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. The next accept is possible on the edge ending RESP+1; back-to-back gap is one cycle.
- ram_wren=1 only in WR. ram_addr is stable from cycle 1 through WR.
- A counter of clog2(RAM_LAT+1) bits times RD/RMW_RD. It clears on entry.

Decomposition:
- Shared package mem_pkg holds:
  - the memory op-code constants (identical values to the core's MEM_ERROR..STORE_WORD);
  - the state enumeration;
  - DEPTH_WORDS default.
- One combinational sub-module, mem_lane_align:
  - inputs: word, addr[1:0], op;
  - outputs: extended load data and merged store word.

Test Plan:
- RAM[0x1000>>2]=0x80FF7F01; LB @0x1003 -> rsp_rdata=0xFFFFFF80, err=0, rsp_valid in cycle 2 (RAM_LAT=1).
- Same word; LHU @0x1002 -> 0x000080FF. LH @0x1002 -> 0xFFFF80FF. LW @0x1000 -> 0x80FF7F01.
- SB wdata=0x000000AB @0x1001 -> single ram_wren pulse with ram_wdata=0x80FFAB01. A following LW returns 0x80FFAB01. rsp in cycle 3.
- LW @0x1002, SH @0x1001, op=9, LW @DEPTH_WORDS*4 -> each gives rsp_err=1, rsp_rdata=0, rsp_valid in cycle 1, ram_wren never asserted.
- req_valid held high for SW then LW back-to-back -> second accept only after RESP. req_ready=0 during WR/RESP. Exactly two rsp pulses.
- Assert rst low during WR of an SB -> ram_wren falls immediately. Outputs return to reset values. RAM word unchanged if reset precedes the WR edge.
